// File: rtl/ft_cmd_parser_pkg.sv
// ============================================================================
// Module : ft_cmd_pkg
// Desc   : Shared types, state encodings and protocol constants for the
//          FT232H command parser.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ft_cmd_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [15:0] word_t;
    typedef logic [3:0]  state_t;

    localparam logic [3:0] S_HUNT     = 4'd0;
    localparam logic [3:0] S_OP       = 4'd1;
    localparam logic [3:0] S_ADDR     = 4'd2;
    localparam logic [3:0] S_DHI      = 4'd3;
    localparam logic [3:0] S_DLO      = 4'd4;
    localparam logic [3:0] S_CSUM     = 4'd5;
    localparam logic [3:0] S_EXEC     = 4'd6;
    localparam logic [3:0] S_RDWAIT   = 4'd7;
    localparam logic [3:0] S_RESP_HDR = 4'd8;
    localparam logic [3:0] S_RESP_DAT = 4'd9;

    localparam byte_t SYNC_BYTE = 8'hA5;
    localparam byte_t RESP_TAG  = 8'h5A;
    localparam byte_t OP_WR     = 8'h01;
    localparam byte_t OP_RD     = 8'h02;
    localparam byte_t ERR_HDR   = 8'hFF;
    localparam byte_t ERR_CSUM  = 8'h01;
    localparam byte_t ERR_OP    = 8'h02;

    function automatic byte_t calc_csum(input byte_t op, input byte_t addr,
                                        input byte_t dhi, input byte_t dlo);
        return op ^ addr ^ dhi ^ dlo;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ft_cmd_parser_if.sv
// ============================================================================
// Module : ft_cmd_parser_if
// Desc   : RX FIFO read side, TX FIFO write side and register bus bundle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ft_cmd_parser_if;
    import ft_cmd_pkg::*;

    logic  rx_empty;
    byte_t rx_data;
    logic  rx_rdreq;
    logic  tx_full;
    logic  tx_wrreq;
    word_t tx_data;
    logic  reg_wr;
    logic  reg_rd;
    byte_t reg_addr;
    word_t reg_wdata;
    word_t reg_rdata;

    modport master (
        input  rx_empty, rx_data, tx_full, reg_rdata,
        output rx_rdreq, tx_wrreq, tx_data, reg_wr, reg_rd, reg_addr, reg_wdata
    );

    modport slave (
        output rx_empty, rx_data, tx_full, reg_rdata,
        input  rx_rdreq, tx_wrreq, tx_data, reg_wr, reg_rd, reg_addr, reg_wdata
    );

endinterface

`default_nettype wire

// File: rtl/ft_cmd_parser_byte_fetch.sv
// ============================================================================
// Module : ft_byte_fetch
// Desc   : Single-outstanding RX FIFO byte fetcher with inter-byte timeout.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ft_byte_fetch
    import ft_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  wire   clk,
    input  wire   rst,
    input  wire   i_fetch_en,
    input  wire   i_armed,
    input  wire   i_rx_empty,
    input  byte_t i_rx_data,
    output logic  o_rx_rdreq,
    output logic  o_byte_vld,
    output byte_t o_byte,
    output logic  o_pending,
    output logic  o_timeout
);

    localparam int                 c_cnt_w   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_lim = c_cnt_w'(TIMEOUT_CYC - 1);

    logic               r_rdreq_q, w_rdreq_d;
    logic               r_vld_q,   w_vld_d;
    logic [c_cnt_w-1:0] r_cnt_q,   w_cnt_d;

    always_comb begin
        w_rdreq_d = i_fetch_en && !i_rx_empty && !r_rdreq_q;
        w_vld_d   = r_rdreq_q;
        // Counter only runs while a packet is being framed; any consumed byte restarts it.
        w_cnt_d   = (!i_armed || r_vld_q) ? '0 : r_cnt_q + c_cnt_w'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdreq_q <= 1'b0;
            r_vld_q   <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            r_rdreq_q <= w_rdreq_d;
            r_vld_q   <= w_vld_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign o_rx_rdreq = r_rdreq_q;
    assign o_byte_vld = r_vld_q;
    assign o_byte     = i_rx_data;
    assign o_pending  = r_rdreq_q;
    assign o_timeout  = i_armed && !r_vld_q && (r_cnt_q == c_cnt_lim);

endmodule

`default_nettype wire

// File: rtl/ft_cmd_parser.sv
// ============================================================================
// Module : ft_cmd_parser
// Desc   : Frames 6-byte host packets, checks csum, runs one register access
//          and returns a 2-word response to the TX FIFO.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ft_cmd_parser
    import ft_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  wire             clk,
    input  wire             rst,
    ft_cmd_parser_if.master bus,
    output logic            busy,
    output logic [7:0]      err_cnt
);

    logic   w_byte_vld, w_pending, w_timeout, w_fetch_en, w_armed, w_err_inc, w_reg_go;
    byte_t  w_byte;

    state_t r_state_q,     w_state_d;
    byte_t  r_op_q,        w_op_d;
    byte_t  r_addr_q,      w_addr_d;
    byte_t  r_dhi_q,       w_dhi_d;
    byte_t  r_dlo_q,       w_dlo_d;
    logic   r_err_q,       w_err_d;
    word_t  r_resp_dat_q,  w_resp_dat_d;
    logic   r_drop_q,      w_drop_d;
    logic   r_tx_wrreq_q,  w_tx_wrreq_d;
    word_t  r_tx_data_q,   w_tx_data_d;
    logic   r_reg_wr_q,    w_reg_wr_d;
    logic   r_reg_rd_q,    w_reg_rd_d;
    byte_t  r_reg_addr_q,  w_reg_addr_d;
    word_t  r_reg_wdata_q, w_reg_wdata_d;
    logic   r_busy_q,      w_busy_d;
    byte_t  r_err_cnt_q,   w_err_cnt_d;

    assign w_armed    = (r_state_q >= S_OP) && (r_state_q <= S_CSUM);
    // Fetch from the next state so nothing is popped once the csum byte closes the packet.
    assign w_fetch_en = (w_state_d <= S_CSUM);

    ft_byte_fetch #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_fetch (
        .clk        (clk),
        .rst        (rst),
        .i_fetch_en (w_fetch_en),
        .i_armed    (w_armed),
        .i_rx_empty (bus.rx_empty),
        .i_rx_data  (bus.rx_data),
        .o_rx_rdreq (bus.rx_rdreq),
        .o_byte_vld (w_byte_vld),
        .o_byte     (w_byte),
        .o_pending  (w_pending),
        .o_timeout  (w_timeout)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_op_d       = r_op_q;
        w_addr_d     = r_addr_q;
        w_dhi_d      = r_dhi_q;
        w_dlo_d      = r_dlo_q;
        w_err_d      = r_err_q;
        w_resp_dat_d = r_resp_dat_q;
        w_drop_d     = r_drop_q;
        w_err_inc    = 1'b0;
        case (r_state_q)
            S_HUNT: if (w_byte_vld) begin
                if (r_drop_q)                w_drop_d  = 1'b0;
                else if (w_byte == SYNC_BYTE) w_state_d = S_OP;
            end
            S_OP:   if (w_byte_vld) begin w_op_d   = w_byte; w_state_d = S_ADDR; end
            S_ADDR: if (w_byte_vld) begin w_addr_d = w_byte; w_state_d = S_DHI;  end
            S_DHI:  if (w_byte_vld) begin w_dhi_d  = w_byte; w_state_d = S_DLO;  end
            S_DLO:  if (w_byte_vld) begin w_dlo_d  = w_byte; w_state_d = S_CSUM; end
            S_CSUM: if (w_byte_vld) begin
                if (w_byte != calc_csum(r_op_q, r_addr_q, r_dhi_q, r_dlo_q)) begin
                    w_err_d      = 1'b1;
                    w_resp_dat_d = {8'h00, ERR_CSUM};
                    w_err_inc    = 1'b1;
                    w_state_d    = S_RESP_HDR;
                end else if (r_op_q != OP_WR && r_op_q != OP_RD) begin
                    w_err_d      = 1'b1;
                    w_resp_dat_d = {8'h00, ERR_OP};
                    w_err_inc    = 1'b1;
                    w_state_d    = S_RESP_HDR;
                end else begin
                    w_err_d      = 1'b0;
                    w_state_d    = S_EXEC;
                end
            end
            S_EXEC: if (r_op_q == OP_WR) begin
                w_resp_dat_d = r_reg_wdata_q;
                w_state_d    = S_RESP_HDR;
            end else begin
                w_state_d    = S_RDWAIT;
            end
            S_RDWAIT: begin
                w_resp_dat_d = bus.reg_rdata;
                w_state_d    = S_RESP_HDR;
            end
            S_RESP_HDR: if (r_tx_wrreq_q) w_state_d = S_RESP_DAT;
            S_RESP_DAT: if (r_tx_wrreq_q) w_state_d = S_HUNT;
            default:    w_state_d = S_HUNT;
        endcase
        // A byte still in flight at timeout must not be mistaken for a fresh sync.
        if (w_timeout) begin
            w_state_d = S_HUNT;
            w_err_inc = 1'b1;
            w_drop_d  = w_pending;
        end
    end

    always_comb begin
        // A word is committed in the cycle tx_wrreq is high; the state advances on that commit.
        w_tx_wrreq_d  = !bus.tx_full
                        && (w_state_d == S_RESP_HDR || w_state_d == S_RESP_DAT)
                        && !(w_state_d == r_state_q && r_tx_wrreq_q);
        w_tx_data_d   = r_tx_data_q;
        if (w_tx_wrreq_d) begin
            if (w_state_d == S_RESP_HDR)
                w_tx_data_d = w_err_d ? {RESP_TAG, ERR_HDR} : {RESP_TAG, r_reg_addr_q};
            else
                w_tx_data_d = w_resp_dat_d;
        end
        w_reg_go      = (w_state_d == S_EXEC) && (r_state_q != S_EXEC);
        w_reg_wr_d    = w_reg_go && (r_op_q == OP_WR);
        w_reg_rd_d    = w_reg_go && (r_op_q == OP_RD);
        w_reg_addr_d  = w_reg_go ? r_addr_q : r_reg_addr_q;
        w_reg_wdata_d = w_reg_go ? {r_dhi_q, r_dlo_q} : r_reg_wdata_q;
        w_busy_d      = (w_state_d != S_HUNT);
        w_err_cnt_d   = (w_err_inc && r_err_cnt_q != 8'hFF) ? r_err_cnt_q + 8'd1 : r_err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= S_HUNT;
            r_op_q        <= '0;
            r_addr_q      <= '0;
            r_dhi_q       <= '0;
            r_dlo_q       <= '0;
            r_err_q       <= 1'b0;
            r_resp_dat_q  <= '0;
            r_drop_q      <= 1'b0;
            r_tx_wrreq_q  <= 1'b0;
            r_tx_data_q   <= '0;
            r_reg_wr_q    <= 1'b0;
            r_reg_rd_q    <= 1'b0;
            r_reg_addr_q  <= '0;
            r_reg_wdata_q <= '0;
            r_busy_q      <= 1'b0;
            r_err_cnt_q   <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_op_q        <= w_op_d;
            r_addr_q      <= w_addr_d;
            r_dhi_q       <= w_dhi_d;
            r_dlo_q       <= w_dlo_d;
            r_err_q       <= w_err_d;
            r_resp_dat_q  <= w_resp_dat_d;
            r_drop_q      <= w_drop_d;
            r_tx_wrreq_q  <= w_tx_wrreq_d;
            r_tx_data_q   <= w_tx_data_d;
            r_reg_wr_q    <= w_reg_wr_d;
            r_reg_rd_q    <= w_reg_rd_d;
            r_reg_addr_q  <= w_reg_addr_d;
            r_reg_wdata_q <= w_reg_wdata_d;
            r_busy_q      <= w_busy_d;
            r_err_cnt_q   <= w_err_cnt_d;
        end
    end

    assign bus.tx_wrreq  = r_tx_wrreq_q;
    assign bus.tx_data   = r_tx_data_q;
    assign bus.reg_wr    = r_reg_wr_q;
    assign bus.reg_rd    = r_reg_rd_q;
    assign bus.reg_addr  = r_reg_addr_q;
    assign bus.reg_wdata = r_reg_wdata_q;
    assign busy          = r_busy_q;
    assign err_cnt       = r_err_cnt_q;

endmodule

`default_nettype wire
